// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and instruction-format constants shared by fetch and decode.
package fetch_pkg;
  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_OPR   = 3'd1,
    S_HOLD  = 3'd2,
    S_FLUSH = 3'd3,
    S_ERR   = 3'd4
  } fetch_state_e;
  localparam int         OP_LEN2_BIT = 7;
  localparam logic [7:0] NOP_OPERAND = 8'h00;
endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: wait-cycle counter that flags a memory request outstanding for TIMEOUT_CYCLES.
// Present only when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic wait_i,
  output logic hit_o
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = wait_i ? cnt_q + 8'd1 : 8'd0;
  // Fires on the edge that completes the last allowed waiting cycle.
  assign hit_o = wait_i && cnt_q == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 1/2-byte instructions over a req/ready handshake into a held IR.
// Optional FETCH_TIMEOUT_EN adds a sticky timeout error state exited only by FLUSH.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] PC_in,
  output logic       I_PC,
  output logic       IM_req,
  output logic [7:0] IM_addr,
  input  logic       IM_ready,
  input  logic [7:0] IM_data,
  input  logic       FLUSH,
  input  logic       IR_ack,
  output logic       IR_valid,
  output logic [7:0] IR_op,
  output logic [7:0] IR_operand,
  output logic       IR_len2,
  output logic       FETCH_ERR
);
  fetch_state_e state_q, state_d;
  logic [7:0]   ir_op_q, ir_operand_q;
  logic         ir_len2_q, take, timeout;

  assign IM_req     = state_q == S_OP || state_q == S_OPR;
  assign IM_addr    = PC_in;
  assign take       = IM_ready & IM_req & ~FLUSH;
  assign I_PC       = take;
  assign IR_valid   = state_q == S_HOLD;
  assign IR_op      = ir_op_q;
  assign IR_operand = ir_operand_q;
  assign IR_len2    = ir_len2_q;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .wait_i (IM_req & ~IM_ready & ~FLUSH),
    .hit_o  (timeout)
  );
  assign FETCH_ERR = state_q == S_ERR;
`else
  logic [7:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
  assign timeout   = 1'b0;
  assign FETCH_ERR = 1'b0;
`endif

  // FLUSH outranks everything, including a byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (FLUSH) state_d = S_FLUSH;
    else if (timeout) state_d = S_ERR;
    else
      case (state_q)
        S_OP:    if (take) state_d = IM_data[OP_LEN2_BIT] ? S_OPR : S_HOLD;
        S_OPR:   if (take) state_d = S_HOLD;
        S_HOLD:  if (IR_ack) state_d = S_OP;
        S_FLUSH: state_d = S_OP;
        default: state_d = state_q;
      endcase
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q      <= S_OP;
      ir_op_q      <= 8'h00;
      ir_operand_q <= 8'h00;
      ir_len2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take && state_q == S_OP) begin
        ir_op_q   <= IM_data;
        ir_len2_q <= IM_data[OP_LEN2_BIT];
        if (!IM_data[OP_LEN2_BIT]) ir_operand_q <= NOP_OPERAND;
      end
      if (take && state_q == S_OPR) ir_operand_q <= IM_data;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with a PC model and a wait-state memory responder.
module tb_instr_fetch_unit;
  logic       CLK = 1'b0;
  logic       RST_N, FLUSH, IR_ack, IM_ready;
  logic       I_PC, IM_req, IR_valid, IR_len2, FETCH_ERR;
  logic [7:0] PC_in, IM_addr, IM_data, IR_op, IR_operand;
  logic [7:0] mem [256];
  logic [7:0] pc, ld_val;
  logic       ld, stall;
  int         waits;
  int         checks = 0, errors = 0;

  typedef struct packed {logic [7:0] op; logic [7:0] opr; logic len2;} ir_t;
  ir_t exp_q[$];

`ifdef FETCH_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  instr_fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .PC_in(PC_in), .I_PC(I_PC), .IM_req(IM_req),
    .IM_addr(IM_addr), .IM_ready(IM_ready), .IM_data(IM_data), .FLUSH(FLUSH),
    .IR_ack(IR_ack), .IR_valid(IR_valid), .IR_op(IR_op), .IR_operand(IR_operand),
    .IR_len2(IR_len2), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  assign PC_in   = pc;
  assign IM_data = mem[IM_addr];

  always @(posedge CLK)
    if (ld) pc <= ld_val;
    else if (I_PC) pc <= pc + 8'd1;

  initial begin
    int wcnt;
    IM_ready = 1'b0;
    wcnt = 0;
    forever begin
      @(negedge CLK);
      if (IM_req === 1'b1 && !stall) begin
        if (wcnt >= waits) begin IM_ready = 1'b1; wcnt = 0; end
        else begin IM_ready = 1'b0; wcnt++; end
      end else begin
        IM_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] op, input logic [7:0] opr);
    mem[a] = op;
    if (op[7]) mem[a + 8'd1] = opr;
    exp_q.push_back('{op, op[7] ? opr : 8'h00, op[7]});
  endtask

  task automatic set_pc(input logic [7:0] v);
    FLUSH = 1'b1; ld = 1'b1; ld_val = v;
    tick();
    FLUSH = 1'b0; ld = 1'b0;
    tick();
  endtask

  task automatic check_ir(input int budget, input string nm);
    ir_t e;
    int n = 0;
    while (!IR_valid && n < budget) begin tick(); n++; end
    checks++;
    if (IR_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid got %b want 1", nm, IR_valid);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue got empty want entry", nm);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({IR_op, IR_operand, IR_len2} !== e) begin
        errors++;
        $display("FAIL %s_ir got %h/%h/%b want %h/%h/%b", nm, IR_op, IR_operand, IR_len2, e.op, e.opr, e.len2);
      end
    end
  endtask

  task automatic ack_ir(input bit stop, input string nm);
    stall = stop;
    IR_ack = 1'b1;
    tick();
    IR_ack = 1'b0;
    checks++;
    if (IR_valid !== 1'b0 || IM_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack got valid=%b req=%b want 0/1", nm, IR_valid, IM_req);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; stall = 1'b1; ld = 1'b1; ld_val = 8'h10;
    tick(); tick();
    checks++;
    if ({IR_valid, IR_op, IR_operand, IR_len2, FETCH_ERR} !== 19'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b op=%h opr=%h l2=%b err=%b want 0/00/00/0/0",
               IR_valid, IR_op, IR_operand, IR_len2, FETCH_ERR);
    end
    RST_N = 1'b1; ld = 1'b0;
    tick();
    checks++;
    if (IM_req !== 1'b1 || IM_addr !== 8'h10) begin
      errors++;
      $display("FAIL reset_release got req=%b addr=%h want 1/10", IM_req, IM_addr);
    end
  endtask

  task automatic test_one_byte();
    put(8'h10, 8'h25, 8'h00);
    waits = 0; stall = 1'b0;
    tick();
    checks++;
    if (I_PC !== 1'b1 || IR_valid !== 1'b0) begin
      errors++;
      $display("FAIL one_byte_ipc got ipc=%b valid=%b want 1/0", I_PC, IR_valid);
    end
    tick();
    checks++;
    if (IR_valid !== 1'b1 || PC_in !== 8'h11) begin
      errors++;
      $display("FAIL one_byte_latency got valid=%b pc=%h want 1/11", IR_valid, PC_in);
    end
    check_ir(0, "one_byte");
    ack_ir(1'b1, "one_byte");
  endtask

  task automatic test_two_byte();
    int n = 0, pulses = 0;
    bit prev_wait = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    put(8'h11, 8'h8A, 8'h3C);
    waits = 2; stall = 1'b0;
    IR_ack = 1'b1;
    while (!IR_valid && n < 30) begin
      tick(); n++;
      if (prev_wait) begin
        checks++;
        if (IM_addr !== prev_addr) begin
          errors++;
          $display("FAIL two_byte_addr_stable got %h want %h", IM_addr, prev_addr);
        end
      end
      prev_wait = IM_req && !IM_ready;
      prev_addr = IM_addr;
      if (I_PC) pulses++;
      IR_ack = pulses < 2;
    end
    IR_ack = 1'b0;
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL two_byte_ipc got %0d want 2", pulses);
    end
    check_ir(0, "two_byte");
  endtask

  task automatic test_hold();
    waits = 0; stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({IR_valid, IR_op, IR_operand, IM_req, I_PC} !== {1'b1, 8'h8A, 8'h3C, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d got v=%b op=%h opr=%h req=%b ipc=%b want 1/8a/3c/0/0",
                 i, IR_valid, IR_op, IR_operand, IM_req, I_PC);
      end
    end
    ack_ir(1'b1, "hold");
  endtask

  task automatic test_flush();
    int n = 0;
    mem[8'h13] = 8'h9F;
    mem[8'h14] = 8'h77;
    put(8'h40, 8'h05, 8'h00);
    waits = 0; stall = 1'b0;
    while (!I_PC && n < 10) begin tick(); n++; end
    tick();
    checks++;
    if (I_PC !== 1'b1 || IM_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got ipc=%b req=%b want 1/1", I_PC, IM_req);
    end
    FLUSH = 1'b1; ld = 1'b1; ld_val = 8'h40;
    #1;
    checks++;
    if (I_PC !== 1'b0) begin
      errors++;
      $display("FAIL flush_ipc got %b want 0", I_PC);
    end
    tick();
    FLUSH = 1'b0; ld = 1'b0;
    checks++;
    if (IR_valid !== 1'b0 || IM_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble got valid=%b req=%b want 0/0", IR_valid, IM_req);
    end
    tick();
    checks++;
    if (IM_req !== 1'b1 || IM_addr !== 8'h40) begin
      errors++;
      $display("FAIL flush_resume got req=%b addr=%h want 1/40", IM_req, IM_addr);
    end
    check_ir(5, "flush");
    ack_ir(1'b1, "flush");
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [6] = '{8'h01, 8'h85, 8'h7F, 8'hC0, 8'h00, 8'h80};
    logic [7:0] oprs[6] = '{8'h00, 8'h11, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic [7:0] a = 8'h80;
    set_pc(8'h80);
    for (int i = 0; i < 6; i++) begin
      put(a, ops[i], oprs[i]);
      a = a + (ops[i][7] ? 8'd2 : 8'd1);
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      waits = $urandom_range(0, 2);
      check_ir(20, "b2b");
      ack_ir(i == 5, "b2b");
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_pc(8'hA0);
    mem[8'hA0] = 8'hC1;
    mem[8'hA1] = 8'h5A;
    waits = 3; stall = 1'b0;
    while (!I_PC && n < 20) begin tick(); n++; end
    tick();
    checks++;
    if (IM_req !== 1'b1 || IR_op !== 8'hC1) begin
      errors++;
      $display("FAIL rst_mid_pre got req=%b op=%h want 1/c1", IM_req, IR_op);
    end
    RST_N = 1'b0; stall = 1'b1;
    #1;
    checks++;
    if (IR_valid !== 1'b0 || IR_op !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_async got valid=%b op=%h want 0/00", IR_valid, IR_op);
    end
    tick();
    RST_N = 1'b1;
    tick();
    checks++;
    if (IM_req !== 1'b1 || IM_addr !== 8'hA1) begin
      errors++;
      $display("FAIL rst_mid_release got req=%b addr=%h want 1/a1", IM_req, IM_addr);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    stall = 1'b1;
    set_pc(8'h50);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (FETCH_ERR !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early_%0d got %b want 0", i, FETCH_ERR);
      end
    end
    tick();
    checks++;
    if (FETCH_ERR !== 1'b1 || IM_req !== 1'b0 || IR_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit got err=%b req=%b valid=%b want 1/0/0", FETCH_ERR, IM_req, IR_valid);
    end
    tick(); tick();
    checks++;
    if (FETCH_ERR !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b want 1", FETCH_ERR);
    end
    put(8'h60, 8'h01, 8'h00);
    set_pc(8'h60);
    stall = 1'b0; waits = 0;
    checks++;
    if (FETCH_ERR !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 0", FETCH_ERR);
    end
    check_ir(5, "timeout");
    ack_ir(1'b1, "timeout");
  endtask
`endif

  initial begin
    FLUSH = 1'b0; IR_ack = 1'b0; ld = 1'b0; ld_val = 8'h00; stall = 1'b1; waits = 0;
    test_reset();
    test_one_byte();
    test_two_byte();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
